// File: rtl/buscaminas_pkg.sv
// buscaminas_pkg: shared types, board size and cursor wrap helper
package buscaminas_pkg;

    typedef enum logic [1:0] {DIR_ARRIBA, DIR_ABAJO, DIR_IZQ, DIR_DER} dir_t;

    typedef enum logic [1:0] {IDLE, ESPERA, REPETIR} cursor_estado_t;

    localparam int TABLERO_N = 8;

    function automatic logic [2:0] paso(input logic [2:0] v, input logic sube, input int n);
        return sube ? ((v == 3'(n - 1)) ? 3'd0 : v + 3'd1)
                    : ((v == 3'd0) ? 3'(n - 1) : v - 3'd1);
    endfunction

endpackage

// File: rtl/cursor_tablero_ctrl_antirrebote.sv
// antirrebote: two-flop synchronizer followed by a consecutive-stable-cycles debouncer
module antirrebote #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic entrada,
    output logic salida
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] FIN = CW'(DEBOUNCE_CICLOS - 1);

    logic s1, s2;
    logic [CW-1:0] cnt;

    // sync the raw button, then flip the level once the new value has held long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            salida <= 1'b0;
        end else begin
            s1 <= entrada;
            s2 <= s1;
            if (s2 == salida)
                cnt <= '0;
            else if (cnt == FIN) begin
                cnt    <= '0;
                salida <= s2;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cursor_tablero_ctrl.sv
// cursor_tablero_ctrl: debounced button cursor with wrap-around, auto-repeat and select pulse
module cursor_tablero_ctrl
    import buscaminas_pkg::*;
#(
    parameter int FILAS           = TABLERO_N,
    parameter int COLUMNAS        = TABLERO_N,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_sel,
    input  logic       juego_activo,
    output logic [2:0] fila,
    output logic [2:0] columna,
    output logic       mover_pulso,
    output logic       sel_pulso
);

    localparam int CW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [CW-1:0] DELAY_FIN = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_FIN  = CW'(REPEAT_RATE - 1);

    logic [4:0] crudo, deb;
    assign crudo = {btn_sel, btn_der, btn_izq, btn_abajo, btn_arriba};

    genvar i;
    generate
        for (i = 0; i < 5; i++) begin : g_btn
            antirrebote #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_ar (
                .clk    (clk),
                .rst_n  (rst_n),
                .entrada(crudo[i]),
                .salida (deb[i])
            );
        end
    endgenerate

    cursor_estado_t estado;
    dir_t           dir, elegida, mdir;
    logic [CW-1:0]  cnt;
    logic           sel_prev, alguna, sostenida, vence, mover;
    logic [2:0]     fila_sig, columna_sig;

    // direction priority, repeat timing and the wrapped next cursor position
    always_comb begin
        alguna      = |deb[3:0];
        elegida     = deb[0] ? DIR_ARRIBA : deb[1] ? DIR_ABAJO : deb[2] ? DIR_IZQ : DIR_DER;
        sostenida   = deb[dir];
        vence       = cnt == ((estado == ESPERA) ? DELAY_FIN : RATE_FIN);
        mdir        = (estado == IDLE) ? elegida : dir;
        mover       = juego_activo && ((estado == IDLE) ? alguna : (sostenida && vence));
        fila_sig    = (mdir == DIR_ARRIBA || mdir == DIR_ABAJO) ? paso(fila, mdir == DIR_ABAJO, FILAS) : fila;
        columna_sig = (mdir == DIR_IZQ || mdir == DIR_DER) ? paso(columna, mdir == DIR_DER, COLUMNAS) : columna;
    end

    // direction ownership FSM, cursor registers and select edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= IDLE;
            dir         <= DIR_ARRIBA;
            cnt         <= '0;
            fila        <= 3'd0;
            columna     <= 3'd0;
            mover_pulso <= 1'b0;
            sel_pulso   <= 1'b0;
            sel_prev    <= 1'b0;
        end else begin
            mover_pulso <= mover;
            sel_prev    <= deb[4];
            sel_pulso   <= juego_activo && deb[4] && !sel_prev;
            if (mover) begin
                fila    <= fila_sig;
                columna <= columna_sig;
            end
            if (!juego_activo) begin
                estado <= IDLE;
                cnt    <= '0;
            end else begin
                case (estado)
                    IDLE: begin
                        cnt <= '0;
                        if (alguna) begin
                            dir    <= elegida;
                            estado <= ESPERA;
                        end
                    end
                    default: begin
                        if (!sostenida) begin
                            estado <= IDLE;
                            cnt    <= '0;
                        end else if (vence) begin
                            estado <= REPETIR;
                            cnt    <= '0;
                        end else
                            cnt <= cnt + 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cursor_tablero_ctrl.sv
// tb_cursor_tablero_ctrl: directed self-checking bench for the cursor controller
module tb_cursor_tablero_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btns = 5'd0;
    logic       juego_activo = 1'b1;
    logic [2:0] fila, columna;
    logic       mover_pulso, sel_pulso;

    int checks = 0;
    int failures = 0;
    int movs = 0;
    int sels = 0;

    localparam logic [4:0] ARR = 5'b00001;
    localparam logic [4:0] ABA = 5'b00010;
    localparam logic [4:0] IZQ = 5'b00100;
    localparam logic [4:0] DER = 5'b01000;
    localparam logic [4:0] SEL = 5'b10000;

    cursor_tablero_ctrl #(
        .FILAS(8), .COLUMNAS(8), .DEBOUNCE_CICLOS(4), .REPEAT_DELAY(10), .REPEAT_RATE(5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_arriba  (btns[0]),
        .btn_abajo   (btns[1]),
        .btn_izq     (btns[2]),
        .btn_der     (btns[3]),
        .btn_sel     (btns[4]),
        .juego_activo(juego_activo),
        .fila        (fila),
        .columna     (columna),
        .mover_pulso (mover_pulso),
        .sel_pulso   (sel_pulso)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mover_pulso) movs++;
        if (sel_pulso) sels++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic press(input logic [4:0] b, input int hold, input int settle);
        btns = b;
        tick(hold);
        btns = 5'd0;
        tick(settle);
    endtask

    int m0, s0, n;
    int tiempos[5] = '{7, 17, 22, 27, 32};

    initial begin
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rst_fila", fila, 0);
        check("rst_col", columna, 0);
        check("rst_mov", mover_pulso, 0);
        check("rst_sel", sel_pulso, 0);

        // first press latency
        m0 = movs;
        btns = ABA;
        tick(6);
        check("lat_e6", fila, 0);
        tick(1);
        check("lat_e7", fila, 1);
        check("lat_pulse", mover_pulso, 1);
        tick(1);
        btns = 5'd0;
        tick(15);
        check("lat_moves", movs - m0, 1);

        // glitchy der must not move
        reset_dut();
        m0 = movs;
        btns = DER; tick(3);
        btns = 5'd0; tick(1);
        btns = DER; tick(3);
        btns = 5'd0; tick(15);
        check("glitch_col", columna, 0);
        check("glitch_moves", movs - m0, 0);

        // wrap-around
        reset_dut();
        press(ARR, 8, 15);
        check("wrap_arr", fila, 7);
        press(IZQ, 8, 15);
        check("wrap_izq", columna, 7);
        check("wrap_fila_kept", fila, 7);
        press(DER, 8, 15);
        check("wrap_der", columna, 0);

        // auto-repeat: 30 held cycles -> moves at 7,17,22,27,32
        reset_dut();
        n = 0;
        btns = DER;
        for (int i = 1; i <= 45; i++) begin
            if (i == 31) btns = 5'd0;
            tick(1);
            if (mover_pulso) begin
                if (n < 5) begin
                    check("rep_time", i, tiempos[n]);
                    check("rep_col", columna, n + 1);
                end
                n++;
            end
        end
        check("rep_count", n, 5);
        check("rep_final", columna, 5);

        // simultaneous press, arriba wins, then der taken after release
        reset_dut();
        for (int k = 0; k < 3; k++) press(ABA, 8, 12);
        for (int k = 0; k < 3; k++) press(DER, 8, 12);
        check("sim_start_f", fila, 3);
        check("sim_start_c", columna, 3);
        btns = ARR | DER;
        tick(5);
        btns = DER;
        tick(2);
        check("sim_f", fila, 2);
        check("sim_c", columna, 3);
        tick(1);
        btns = 5'd0;
        tick(4);
        check("sim_c_e12", columna, 3);
        tick(1);
        check("sim_c_e13", columna, 4);
        check("sim_pulse", mover_pulso, 1);
        tick(15);
        check("sim_end_f", fila, 2);
        check("sim_end_c", columna, 4);

        // select pulse, no repeat while held
        reset_dut();
        s0 = sels;
        press(SEL, 20, 15);
        check("sel_once", sels - s0, 1);

        // disabled: no select, no move
        juego_activo = 1'b0;
        s0 = sels;
        m0 = movs;
        press(SEL | ABA, 10, 15);
        check("dis_sel", sels - s0, 0);
        check("dis_mov", movs - m0, 0);
        check("dis_fila", fila, 0);

        // re-enable with sel held -> no pulse
        btns = SEL;
        tick(10);
        juego_activo = 1'b1;
        tick(5);
        check("reen_sel", sels - s0, 0);
        btns = 5'd0;
        tick(15);

        // abajo held across enable -> moves on next edge
        juego_activo = 1'b0;
        btns = ABA;
        tick(10);
        juego_activo = 1'b1;
        tick(1);
        check("reen_fila", fila, 1);
        check("reen_pulse", mover_pulso, 1);
        btns = 5'd0;
        tick(15);
        check("reen_fila_end", fila, 1);

        // reset mid-REPETIR
        btns = DER;
        tick(20);
        check("mid_col", columna, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_fila", fila, 0);
        check("arst_col", columna, 0);
        check("arst_mov", mover_pulso, 0);
        check("arst_sel", sel_pulso, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("redeb_col_early", columna, 0);
        tick(4);
        check("redeb_col", columna, 1);
        btns = 5'd0;
        tick(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
